// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, NOP encoding,
// fetch FSM state encoding and the fetch-buffer entry layout.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR_WORD = 32'hD503_201F;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch advance; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Circular buffer of fetched {pc, instr} entries with flush. Also exposes the head as it
// will stand after this cycle's push/pop/flush so the caller can register it directly.
module fetch_buffer_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_nxt_valid,
  output fetch_entry_t           head_nxt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [CNT_W-1:0] count_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Next pointers and occupancy; flush overrides push and pop.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    wr_ptr_s  = wr_ptr_r;
    rd_ptr_s  = rd_ptr_r;
    count_s   = count_r;
    if (flush) begin
      wr_ptr_s = '0;
      rd_ptr_s = '0;
      count_s  = '0;
    end else begin
      do_push_s = push && (count_r != CNT_FULL);
      do_pop_s  = pop && (count_r != '0);
      if (do_push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (do_push_s && !do_pop_s) begin
        count_s = count_r + CNT_ONE;
      end else if (!do_push_s && do_pop_s) begin
        count_s = count_r - CNT_ONE;
      end else begin
        count_s = count_r;
      end
    end
  end

  // Post-update head, bypassing the write when the pushed slot becomes the head.
  always_comb begin
    head_nxt_valid = (count_s != '0);
    if (do_push_s && (wr_ptr_r == rd_ptr_s)) begin
      head_nxt = push_data;
    end else begin
      head_nxt = mem_r[rd_ptr_s];
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem req/ack FSM, fetch buffer,
// and registered {if_valid, ibus_out, pc_out} towards IF/ID.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 64'h0,
  parameter int unsigned        BUF_DEPTH = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] ibus_out,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);

  if_state_e         state_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic              push_s;
  logic              pop_s;
  fetch_entry_t      push_entry_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              head_nxt_valid_s;
  fetch_entry_t      head_nxt_s;

  // Only a response belonging to the live stream is buffered; redirect drops it.
  always_comb begin
    push_entry_s = '{pc: fetch_pc_r, instr: imem_rdata};
    if ((state_r == IF_WAIT) && imem_ack && !redirect) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (if_valid && !id_stall && !redirect) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  fetch_buffer_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (push_s),
    .push_data      (push_entry_s),
    .pop            (pop_s),
    .flush          (redirect),
    .count          (fifo_count_s),
    .head_nxt_valid (head_nxt_valid_s),
    .head_nxt       (head_nxt_s)
  );

  // Fetch FSM; issuing only below full reserves a slot for every response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IF_IDLE;
      fetch_pc_r <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
    end else begin
      case (state_r)
        IF_IDLE: begin
          if (redirect) begin
            fetch_pc_r <= redirect_pc;
          end else if (fifo_count_s < BUF_FULL) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_r;
            state_r   <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (imem_ack) begin
            imem_req   <= 1'b0;
            state_r    <= IF_IDLE;
            fetch_pc_r <= redirect ? redirect_pc : pc_next(fetch_pc_r);
          end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
            state_r    <= IF_DISCARD;
          end
        end
        IF_DISCARD: begin
          // Request stays up until memory answers; the answer is stale.
          if (redirect) begin
            fetch_pc_r <= redirect_pc;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            state_r  <= IF_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state_r  <= IF_IDLE;
        end
      endcase
    end
  end

  // IF/ID output registers follow the buffer head as it stands after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      ibus_out <= NOP_INSTR;
      pc_out   <= '0;
    end else if (head_nxt_valid_s) begin
      if_valid <= 1'b1;
      ibus_out <= head_nxt_s.instr;
      pc_out   <= head_nxt_s.pc;
    end else begin
      if_valid <= 1'b0;
      ibus_out <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming vector table plus hand-written
// reset, backpressure, redirect and PC-wrap sequences.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP  = 32'hD503_201F;
  localparam logic [31:0] A0   = 32'hA000_0000;
  localparam logic [31:0] A1   = 32'hA000_0001;
  localparam logic [31:0] A2   = 32'hA000_0002;
  localparam logic [31:0] A3   = 32'hA000_0003;
  localparam logic [31:0] B0   = 32'hB000_0000;
  localparam logic [31:0] C0   = 32'hC000_0000;
  localparam logic [31:0] C1   = 32'hC000_0001;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [31:0] ibus;
    logic [63:0] pc;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
    out_t w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req,  w_req;
  logic [63:0] imem_addr, w_addr;
  logic        if_valid,  w_valid;
  logic [31:0] ibus_out,  w_ibus;
  logic [63:0] pc_out,    w_pc;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .ibus_out(ibus_out), .pc_out(pc_out)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(w_valid), .ibus_out(w_ibus), .pc_out(w_pc)
  );

  function automatic in_t mk_in(logic ack, logic [31:0] rd, logic st, logic rdr, logic [63:0] rpc);
    in_t r;
    r.ack = ack; r.rdata = rd; r.stall = st; r.redir = rdr; r.rpc = rpc;
    return r;
  endfunction

  function automatic out_t mk_out(logic req, logic [63:0] addr, logic v, logic [31:0] ib, logic [63:0] pc);
    out_t r;
    r.req = req; r.addr = addr; r.valid = v; r.ibus = ib; r.pc = pc;
    return r;
  endfunction

  function automatic vec_t mkv(logic ack, logic [31:0] rd, logic req, logic [63:0] addr, logic v,
                               logic [31:0] ib, logic [63:0] pc, logic [63:0] wa, logic [63:0] wp);
    vec_t r;
    r.i = mk_in(ack, rd, 1'b0, 1'b0, 64'h0);
    r.o = mk_out(req, addr, v, ib, pc);
    r.w = mk_out(req, wa, v, ib, wp);
    return r;
  endfunction

  function automatic out_t dut_out();
    return mk_out(imem_req, imem_addr, if_valid, ibus_out, pc_out);
  endfunction

  function automatic out_t w_out();
    return mk_out(w_req, w_addr, w_valid, w_ibus, w_pc);
  endfunction

  function automatic logic [31:0] word_at(logic [63:0] addr);
    return 32'hA000_0000 + {2'b00, addr[31:2]};
  endfunction

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h valid=%b ibus=%h pc=%h, expected req=%b addr=%h valid=%b ibus=%h pc=%h",
               name, act.req, act.addr, act.valid, act.ibus, act.pc,
               exp.req, exp.addr, exp.valid, exp.ibus, exp.pc);
    end
  endtask

  task automatic chk_bus(input string name, input logic v, input logic [31:0] ib, input logic [63:0] pc);
    n_checks++;
    if ({if_valid, ibus_out, pc_out} !== {v, ib, pc}) begin
      n_fail++;
      $display("FAIL %s: got valid=%b ibus=%h pc=%h, expected valid=%b ibus=%h pc=%h",
               name, if_valid, ibus_out, pc_out, v, ib, pc);
    end
  endtask

  task automatic chk_fetch(input string name, input logic req, input logic [63:0] addr);
    n_checks++;
    if ({imem_req, imem_addr} !== {req, addr}) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h, expected req=%b addr=%h", name, imem_req, imem_addr, req, addr);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    id_stall    = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
  endtask

  // Apply inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input in_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  // Memory model that answers in the first cycle a request is seen.
  task automatic resp_step(input logic stall, output logic acked);
    acked = imem_req;
    step(mk_in(imem_req, word_at(imem_addr), stall, 1'b0, 64'h0));
  endtask

  task automatic do_reset();
    drive(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    rst_n = 1'b0;
    #2;
    chk_out("reset_state", dut_out(), mk_out(1'b0, 64'h0, 1'b0, NOP, 64'h0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("reset_release", dut_out(), mk_out(1'b1, 64'h0, 1'b0, NOP, 64'h0));
    chk_out("wrap_release", w_out(), mk_out(1'b1, WRAP_PC, 1'b0, NOP, 64'h0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic acked;
    logic found;
    int   n_acks;

    // ack  rdata  | req addr   valid ibus pc      | wrap addr / pc
    vecs[0] = mkv(1'b1, A0,    1'b0, 64'h0,  1'b1, A0,  64'h0, WRAP_PC, WRAP_PC);
    vecs[1] = mkv(1'b0, 32'h0, 1'b1, 64'h4,  1'b0, NOP, 64'h0, 64'h0,   WRAP_PC);
    vecs[2] = mkv(1'b1, A1,    1'b0, 64'h4,  1'b1, A1,  64'h4, 64'h0,   64'h0);
    vecs[3] = mkv(1'b0, 32'h0, 1'b1, 64'h8,  1'b0, NOP, 64'h4, 64'h4,   64'h0);
    vecs[4] = mkv(1'b1, A2,    1'b0, 64'h8,  1'b1, A2,  64'h8, 64'h4,   64'h4);
    vecs[5] = mkv(1'b0, 32'h0, 1'b1, 64'hC,  1'b0, NOP, 64'h8, 64'h8,   64'h4);
    vecs[6] = mkv(1'b1, A3,    1'b0, 64'hC,  1'b1, A3,  64'hC, 64'h8,   64'h8);
    vecs[7] = mkv(1'b0, 32'h0, 1'b1, 64'h10, 1'b0, NOP, 64'hC, 64'hC,   64'h8);

    rst_n = 1'b1;
    drive(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    #1;
    do_reset();

    // Streaming, with the wrap instance running in lockstep.
    for (int k = 0; k < 8; k++) begin
      step(vecs[k].i);
      chk_out($sformatf("stream%0d", k), dut_out(), vecs[k].o);
      chk_out($sformatf("wrap%0d", k), w_out(), vecs[k].w);
    end

    // Reset asserted while a request is outstanding.
    chk_fetch("pre_reset_wait", 1'b1, 64'h10);
    do_reset();

    // Backpressure: buffer fills, fetch stops, head stays put.
    n_acks = 0;
    for (int c = 1; c <= 10; c++) begin
      resp_step(1'b1, acked);
      if (acked) n_acks++;
      chk_bus($sformatf("bp_hold%0d", c), 1'b1, A0, 64'h0);
    end
    chk_int("bp_req_count", n_acks, 2);
    resp_step(1'b0, acked);
    chk_bus("bp_release_a1", 1'b1, A1, 64'h4);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      resp_step(1'b0, acked);
      found = if_valid;
    end
    chk_bus("bp_next_a2", 1'b1, A2, 64'h8);

    // Redirect while waiting, stale answer arrives three cycles later.
    do_reset();
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b1, 64'h100));
    chk_out("rd_discard_hold", dut_out(), mk_out(1'b1, 64'h0, 1'b0, NOP, 64'h0));
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    chk_fetch("rd_still_waiting", 1'b1, 64'h0);
    step(mk_in(1'b1, JUNK, 1'b0, 1'b0, 64'h0));
    chk_out("rd_junk_dropped", dut_out(), mk_out(1'b0, 64'h0, 1'b0, NOP, 64'h0));
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    chk_fetch("rd_new_addr", 1'b1, 64'h100);
    step(mk_in(1'b1, B0, 1'b0, 1'b0, 64'h0));
    chk_bus("rd_first_valid", 1'b1, B0, 64'h100);

    // Redirect coincident with ack and pop, then with pop on a full buffer.
    do_reset();
    step(mk_in(1'b1, A0, 1'b1, 1'b0, 64'h0));
    step(mk_in(1'b0, 32'h0, 1'b1, 1'b0, 64'h0));
    chk_fetch("ra_issue", 1'b1, 64'h4);
    step(mk_in(1'b1, A1, 1'b0, 1'b1, 64'h200));
    chk_out("ra_flush", dut_out(), mk_out(1'b0, 64'h4, 1'b0, NOP, 64'h0));
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    chk_fetch("ra_new_addr", 1'b1, 64'h200);
    step(mk_in(1'b1, C0, 1'b1, 1'b0, 64'h0));
    chk_bus("ra_c0", 1'b1, C0, 64'h200);
    step(mk_in(1'b0, 32'h0, 1'b1, 1'b0, 64'h0));
    chk_fetch("full_issue", 1'b1, 64'h204);
    step(mk_in(1'b1, C1, 1'b1, 1'b0, 64'h0));
    chk_out("full_hold", dut_out(), mk_out(1'b0, 64'h204, 1'b1, C0, 64'h200));
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b1, 64'h300));
    chk_out("full_flush", dut_out(), mk_out(1'b0, 64'h204, 1'b0, NOP, 64'h200));
    step(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0));
    chk_fetch("full_new_addr", 1'b1, 64'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
